// File: rtl/race_pkg.sv
// race_pkg: shared state encoding and width helpers for the race game-flow controller.
// Imported by race_ctrl and tick_div.
package race_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int LVL_W  = 3;
  localparam int LIFE_W = 3;

  // bits needed to hold the value n itself
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tick_div.sv
// tick_div: loadable modulo counter, 0..period-1, with a wrap pulse on the last count.
// clr has priority over en; the counter holds when en is low.
module tick_div
  import race_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic         wrap
);

  logic [W-1:0] cnt;

  assign wrap = en && (cnt == period - W'(1));

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (clr || wrap)
      cnt <= '0;
    else if (en)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/race_ctrl.sv
// race_ctrl: game-flow controller (IDLE/RUN/CRASH/OVER), score, level and playfield strobes.
// Optional pause feature: define RACE_CTRL_PAUSE_EN.
module race_ctrl
  import race_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCORE_W     = 6,
  parameter int LIVES       = 3,
  parameter int LEVELS      = 4,
  parameter int LEVEL_SECS  = 10,
  parameter int BASE_DIV    = 131072,
  parameter int DROP_DIV    = 13282294,
  parameter int FLASH_DIV   = 6_250_000,
  parameter int RESPAWN_CYC = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               collision,
`ifdef RACE_CTRL_PAUSE_EN
  input  logic               pause,
`endif
  output logic               run_tick,
  output logic               fast_tick,
  output logic               drop,
  output logic               alive,
  output logic               flash,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [LVL_W-1:0]   level,
  output logic [LIFE_W-1:0]  lives_left
);

  localparam int SEC_W = cw(CLK_HZ);
  localparam int LS_W  = cw(LEVEL_SECS);
  localparam int SCR_W = cw(BASE_DIV);
  localparam int DRP_W = cw(DROP_DIV);
  localparam int FL_W  = cw(FLASH_DIV);
  localparam int RSP_W = cw(RESPAWN_CYC);

  state_t state, state_n;

  logic start_q, start_rise, pause_rise;
  logic paused, paused_n;
  logic active, hit, en, new_game, go;
  logic in_crash, lvl_bump, scr_clr;
  logic sec_wrap, lvl_wrap, scr_wrap, fst_wrap;
  logic drp_wrap, fl_wrap, rsp_wrap;
  logic [SCR_W-1:0] scr_per, fst_per;

  assign start_rise = start & ~start_q;

`ifdef RACE_CTRL_PAUSE_EN
  logic pause_q;
  always_ff @(posedge clk) pause_q <= pause;
  assign pause_rise = pause & ~pause_q;
`else
  assign pause_rise = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    new_game = 1'b0;
    active   = (state == RUN) && !paused;
    hit      = active && collision;
    unique case (state)
      IDLE, OVER:
        if (start_rise) begin
          state_n  = RUN;
          new_game = 1'b1;
        end
      RUN:
        if (hit) state_n = CRASH;
      CRASH:
        if (rsp_wrap)
          state_n = (lives_left != '0) ? RUN : OVER;
    endcase
    en       = active && !hit;
    paused_n = (state == RUN && state_n == RUN) ?
               (paused ^ pause_rise) : 1'b0;
    go       = (state_n == RUN) && !paused_n;
  end

  assign in_crash = (state == CRASH);
  assign lvl_bump = lvl_wrap && (level != LVL_W'(LEVELS - 1));
  assign scr_clr  = new_game || lvl_bump;

  // scroll period halves per level, never below 2
  always_comb begin
    scr_per = SCR_W'(BASE_DIV >> level);
    if (scr_per < SCR_W'(2)) scr_per = SCR_W'(2);
  end

  // half-period divider kept in phase with the scroll divider
  assign fst_per = scr_per >> 1;

  tick_div #(.W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .en(en), .clr(new_game),
    .period(SEC_W'(CLK_HZ)), .wrap(sec_wrap)
  );

  tick_div #(.W(LS_W)) u_lvl (
    .clk(clk), .reset(reset), .en(sec_wrap), .clr(new_game),
    .period(LS_W'(LEVEL_SECS)), .wrap(lvl_wrap)
  );

  tick_div #(.W(SCR_W)) u_scr (
    .clk(clk), .reset(reset), .en(en), .clr(scr_clr),
    .period(scr_per), .wrap(scr_wrap)
  );

  tick_div #(.W(SCR_W)) u_fst (
    .clk(clk), .reset(reset), .en(en), .clr(scr_clr),
    .period(fst_per), .wrap(fst_wrap)
  );

  tick_div #(.W(DRP_W)) u_drp (
    .clk(clk), .reset(reset), .en(en), .clr(new_game),
    .period(DRP_W'(DROP_DIV)), .wrap(drp_wrap)
  );

  tick_div #(.W(FL_W)) u_fl (
    .clk(clk), .reset(reset), .en(in_crash), .clr(!in_crash),
    .period(FL_W'(FLASH_DIV)), .wrap(fl_wrap)
  );

  tick_div #(.W(RSP_W)) u_rsp (
    .clk(clk), .reset(reset), .en(in_crash), .clr(!in_crash),
    .period(RSP_W'(RESPAWN_CYC)), .wrap(rsp_wrap)
  );

  always_ff @(posedge clk) begin
    start_q <= start;
    if (!reset) begin
      state      <= IDLE;
      paused     <= 1'b0;
      run_tick   <= 1'b0;
      fast_tick  <= 1'b0;
      drop       <= 1'b0;
      alive      <= 1'b0;
      flash      <= 1'b0;
      game_over  <= 1'b0;
      score      <= '0;
      level      <= '0;
      lives_left <= LIFE_W'(LIVES);
    end else begin
      state     <= state_n;
      paused    <= paused_n;
      run_tick  <= scr_wrap && go;
      fast_tick <= fst_wrap && go;
      drop      <= drp_wrap && go;
      alive     <= go;
      game_over <= (state_n == OVER);
      flash     <= (state_n == CRASH) ?
                   ((state != CRASH) || (flash ^ fl_wrap)) :
                   (state_n == OVER);
      if (new_game) begin
        score      <= '0;
        level      <= '0;
        lives_left <= LIFE_W'(LIVES);
      end else begin
        if (sec_wrap && score != '1)
          score <= score + SCORE_W'(1);
        if (lvl_bump)
          level <= level + LVL_W'(1);
        if (hit)
          lives_left <= lives_left - LIFE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_race_ctrl.sv
// tb_race_ctrl: scoreboard bench; a cycle-level game model queues expected outputs,
// a monitor pops and compares them one cycle after each stimulus.
module tb_race_ctrl;

  localparam int CLK_HZ      = 10;
  localparam int SCORE_W     = 6;
  localparam int LIVES       = 2;
  localparam int LEVELS      = 4;
  localparam int LEVEL_SECS  = 2;
  localparam int BASE_DIV    = 8;
  localparam int DROP_DIV    = 5;
  localparam int FLASH_DIV   = 2;
  localparam int RESPAWN_CYC = 6;
  localparam int SMAX        = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic collision = 1'b0;
  logic pause = 1'b0;

  logic run_tick, fast_tick, drop, alive, flash, game_over;
  logic [SCORE_W-1:0] score;
  logic [2:0] level, lives_left;

  race_ctrl #(
    .CLK_HZ(CLK_HZ), .SCORE_W(SCORE_W), .LIVES(LIVES),
    .LEVELS(LEVELS), .LEVEL_SECS(LEVEL_SECS),
    .BASE_DIV(BASE_DIV), .DROP_DIV(DROP_DIV),
    .FLASH_DIV(FLASH_DIV), .RESPAWN_CYC(RESPAWN_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .collision(collision),
`ifdef RACE_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .run_tick(run_tick),
    .fast_tick(fast_tick),
    .drop(drop),
    .alive(alive),
    .flash(flash),
    .game_over(game_over),
    .score(score),
    .level(level),
    .lives_left(lives_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rt, ft, dr, al, fl, go, sc, lv, li;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // game model: 0 idle, 1 run, 2 crash, 3 over
  int m_mode = 0, m_score = 0, m_level = 0, m_lives = LIVES;
  int m_sec = 0, m_secs = 0, m_scr = 0, m_drop = 0, m_age = 0;
  int m_paused = 0, m_sprev = 0, m_pprev = 0;

  function automatic int per(input int lv);
    int p;
    p = BASE_DIV >> lv;
    return (p < 2) ? 2 : p;
  endfunction

  task automatic new_game();
    m_mode = 1; m_score = 0; m_level = 0; m_lives = LIVES;
    m_sec = 0; m_secs = 0; m_scr = 0; m_drop = 0; m_paused = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int srise, prise, p;
    e = '{default: 0};
    if (!reset) begin
      m_mode = 0; m_score = 0; m_level = 0; m_lives = LIVES;
      m_sec = 0; m_secs = 0; m_scr = 0; m_drop = 0;
      m_age = 0; m_paused = 0;
      m_sprev = start; m_pprev = pause;
    end else begin
      srise = int'(start && !m_sprev);
      prise = int'(pause && !m_pprev);
      m_sprev = start;
      m_pprev = pause;
      case (m_mode)
        0, 3: begin
          if (srise != 0) begin
            new_game();
            e.al = 1;
          end else if (m_mode == 3) begin
            e.fl = 1;
            e.go = 1;
          end
        end
        1: begin
          if (m_paused != 0) begin
            if (prise != 0) m_paused = 0;
            e.al = int'(m_paused == 0);
          end else if (collision) begin
            m_mode = 2;
            m_lives = m_lives - 1;
            m_age = 0;
            e.fl = 1;
          end else begin
            p = per(m_level);
            m_paused = prise;
            if (m_paused == 0) begin
              e.rt = int'(m_scr == p - 1);
              e.ft = int'(m_scr == p - 1 || m_scr == p / 2 - 1);
              e.dr = int'(m_drop == DROP_DIV - 1);
              e.al = 1;
            end
            m_scr = (m_scr + 1) % p;
            m_drop = (m_drop + 1) % DROP_DIV;
            m_sec = m_sec + 1;
            if (m_sec == CLK_HZ) begin
              m_sec = 0;
              m_secs = m_secs + 1;
              if (m_score < SMAX) m_score = m_score + 1;
              if (m_secs % LEVEL_SECS == 0 && m_level < LEVELS - 1) begin
                m_level = m_level + 1;
                m_scr = 0;
              end
            end
          end
        end
        default: begin
          m_age = m_age + 1;
          if (m_age == RESPAWN_CYC) begin
            if (m_lives > 0) begin
              m_mode = 1;
              e.al = 1;
            end else begin
              m_mode = 3;
              e.fl = 1;
              e.go = 1;
            end
          end else begin
            e.fl = int'((m_age / FLASH_DIV) % 2 == 0);
          end
        end
      endcase
    end
    e.sc = m_score;
    e.lv = m_level;
    e.li = m_lives;
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic c, input logic p);
    @(negedge clk);
    reset = r;
    start = s;
    collision = c;
`ifdef RACE_CTRL_PAUSE_EN
    pause = p;
`else
    pause = 1'b0;
    if (p) pause = 1'b0;
`endif
    model_step();
  endtask

  task automatic chk(input string n, input logic [31:0] a, input int e);
    checks++;
    if (a !== 32'(e)) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", n, $time, a, e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("run_tick", 32'(run_tick), e.rt);
        chk("fast_tick", 32'(fast_tick), e.ft);
        chk("drop", 32'(drop), e.dr);
        chk("alive", 32'(alive), e.al);
        chk("flash", 32'(flash), e.fl);
        chk("game_over", 32'(game_over), e.go);
        chk("score", 32'(score), e.sc);
        chk("level", 32'(level), e.lv);
        chk("lives_left", 32'(lives_left), e.li);
      end
    end
  end

  initial begin : stim
    logic rs, rp;
    int w;
    rs = 1'b0;
    rp = 1'b0;
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (70) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (8) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (10) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (39) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (5) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (700) cyc(1, 0, 0, 0);
`ifdef RACE_CTRL_PAUSE_EN
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 0, (i % 5 == 2), 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (12) cyc(1, 0, 0, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rs = ~rs;
      if ($urandom_range(0, 24) == 0) rp = ~rp;
      cyc(($urandom_range(0, 399) != 0), rs,
          ($urandom_range(0, 29) == 0), rp);
    end
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      #2;
      w++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
